// File: rtl/fp_add_pipe.sv
// Three-stage pipelined floating-point adder/subtractor with valid/ready handshake.
// Subnormals flush to zero; RNE or RTZ rounding; flags are {invalid, overflow, inexact}.
`timescale 1ns/1ps
module fp_add_pipe #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   in_a,
    input  logic [EXP_W+MAN_W:0]   in_b,
    input  logic                   in_sub,
    input  logic                   in_rnd,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out_x,
    output logic [2:0]             out_flags
);

    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int MW   = MAN_W + 4;  // hidden + fraction + guard/round/sticky
    localparam int SW   = MAN_W + 5;  // MW plus carry-out
    localparam int LZW  = $clog2(SW + 1);
    localparam int EMAX = (1 << EXP_W) - 1;
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    logic stall;
    assign stall     = out_valid & ~out_ready;
    assign in_ready  = ~stall;

    // Stage registers
    logic             s1_valid_q, s2_valid_q, s3_valid_q;
    logic             s1_spec_q, s1_spec_d, s2_spec_q;
    logic [W-1:0]     s1_specx_q, s1_specx_d, s2_specx_q;
    logic [2:0]       s1_specf_q, s1_specf_d, s2_specf_q;
    logic             s1_sign_q, s1_sign_d, s2_sign_q;
    logic             s1_sub_q, s1_sub_d;
    logic             s1_rnd_q, s2_rnd_q;
    logic [EXP_W-1:0] s1_exp_q, s1_exp_d, s2_exp_q;
    logic [MW-1:0]    s1_ml_q, s1_ml_d, s1_ms_q, s1_ms_d;
    logic [SW-1:0]    s2_sum_q, s2_sum_d;
    logic [W-1:0]     s3_x_q, s3_x_d;
    logic [2:0]       s3_f_q, s3_f_d;

    // S1: unpack, classify, swap, align
    logic             sa, sb, a_nan, b_nan, a_inf, b_inf, swap;
    logic [EXP_W-1:0] ea, eb, d_exp;
    logic [MAN_W-1:0] fa, fb;
    logic [MW-1:0]    ma, mb, m_small, m_mask;
    logic [31:0]      shamt;

    always_comb begin
        sa = in_a[W-1];
        ea = in_a[W-2:MAN_W];
        fa = in_a[MAN_W-1:0];
        sb = in_b[W-1] ^ in_sub;
        eb = in_b[W-2:MAN_W];
        fb = in_b[MAN_W-1:0];

        a_nan = (&ea) & (|fa);
        b_nan = (&eb) & (|fb);
        a_inf = (&ea) & ~(|fa);
        b_inf = (&eb) & ~(|fb);

        // Zero exponent (zero or subnormal) flushes to a zero mantissa
        ma = (ea == '0) ? '0 : {1'b1, fa, 3'b000};
        mb = (eb == '0) ? '0 : {1'b1, fb, 3'b000};

        swap      = {eb, mb} > {ea, ma};
        s1_sign_d = swap ? sb : sa;
        s1_exp_d  = swap ? eb : ea;
        s1_ml_d   = swap ? mb : ma;
        m_small   = swap ? ma : mb;
        d_exp     = swap ? (eb - ea) : (ea - eb);
        s1_sub_d  = sa ^ sb;

        shamt  = 32'(d_exp);
        m_mask = ~({MW{1'b1}} << shamt);
        if (shamt >= 32'(MAN_W + 3)) begin
            s1_ms_d = {{(MW-1){1'b0}}, |m_small};
        end else begin
            s1_ms_d = (m_small >> shamt) | {{(MW-1){1'b0}}, |(m_small & m_mask)};
        end

        s1_spec_d  = 1'b0;
        s1_specx_d = QNAN;
        s1_specf_d = 3'b000;
        if (a_nan | b_nan) begin
            s1_spec_d  = 1'b1;
            s1_specf_d = {(a_nan & ~fa[MAN_W-1]) | (b_nan & ~fb[MAN_W-1]), 2'b00};
        end else if (a_inf & b_inf & (sa != sb)) begin
            s1_spec_d  = 1'b1;
            s1_specf_d = 3'b100;
        end else if (a_inf) begin
            s1_spec_d  = 1'b1;
            s1_specx_d = {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (b_inf) begin
            s1_spec_d  = 1'b1;
            s1_specx_d = {sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end
    end

    // S2: magnitude add/subtract; the larger operand is always the minuend
    always_comb begin
        if (s1_sub_q) s2_sum_d = {1'b0, s1_ml_q} - {1'b0, s1_ms_q};
        else          s2_sum_d = {1'b0, s1_ml_q} + {1'b0, s1_ms_q};
    end

    // S3: normalize, round, pack
    logic [LZW-1:0]   lz;
    logic [SW-2:0]    norm;
    logic [MAN_W:0]   m_n;
    logic [MAN_W+1:0] m_r;
    logic [MAN_W-1:0] frac_r;
    logic             g, r, s, up;
    int               e_pre, e_post;

    always_comb begin
        lz = LZW'(SW);
        for (int i = 0; i < SW; i++) begin
            if (s2_sum_q[i]) lz = LZW'(SW - 1 - i);
        end
        if (lz == '0) norm = {s2_sum_q[SW-1:2], s2_sum_q[1] | s2_sum_q[0]};
        else          norm = (SW-1)'(s2_sum_q << (lz - LZW'(1)));

        e_pre  = int'(s2_exp_q) + 1 - int'(lz);
        e_post = e_pre;
        m_n    = norm[SW-2:3];
        g      = norm[2];
        r      = norm[1];
        s      = norm[0];
        up     = ~s2_rnd_q & g & (r | s | m_n[0]);
        m_r    = {1'b0, m_n} + {{(MAN_W+1){1'b0}}, up};
        frac_r = m_r[MAN_W-1:0];
        if (m_r[MAN_W+1]) begin
            e_post = e_pre + 1;
            frac_r = m_r[MAN_W:1];
        end

        s3_x_d = {s2_sign_q, e_post[EXP_W-1:0], frac_r};
        s3_f_d = {2'b00, g | r | s};
        if (s2_spec_q) begin
            s3_x_d = s2_specx_q;
            s3_f_d = s2_specf_q;
        end else if (lz == LZW'(SW)) begin
            s3_x_d = '0;
            s3_f_d = 3'b000;
        end else if (e_pre <= 0) begin
            s3_x_d = {s2_sign_q, {(W-1){1'b0}}};
            s3_f_d = 3'b001;
        end else if (e_post >= EMAX) begin
            s3_f_d = 3'b011;
            if (s2_rnd_q) s3_x_d = {s2_sign_q, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
            else          s3_x_d = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s3_valid_q <= 1'b0;
            s3_x_q     <= '0;
            s3_f_q     <= '0;
        end else if (!stall) begin
            s1_valid_q <= in_valid;
            s2_valid_q <= s1_valid_q;
            s3_valid_q <= s2_valid_q;
            s3_x_q     <= s3_x_d;
            s3_f_q     <= s3_f_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!stall) begin
            s1_spec_q  <= s1_spec_d;
            s1_specx_q <= s1_specx_d;
            s1_specf_q <= s1_specf_d;
            s1_sign_q  <= s1_sign_d;
            s1_sub_q   <= s1_sub_d;
            s1_rnd_q   <= in_rnd;
            s1_exp_q   <= s1_exp_d;
            s1_ml_q    <= s1_ml_d;
            s1_ms_q    <= s1_ms_d;
            s2_spec_q  <= s1_spec_q;
            s2_specx_q <= s1_specx_q;
            s2_specf_q <= s1_specf_q;
            s2_sign_q  <= s1_sign_q;
            s2_rnd_q   <= s1_rnd_q;
            s2_exp_q   <= s1_exp_q;
            s2_sum_q   <= s2_sum_d;
        end
    end

    assign out_valid = s3_valid_q;
    assign out_x     = s3_x_q;
    assign out_flags = s3_f_q;

endmodule

// File: tb/tb_fp_add_pipe.sv
// Scoreboard bench for fp_add_pipe: single and half precision instances, directed vectors.
`timescale 1ns/1ps
module tb_fp_add_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, in_ready, in_sub, in_rnd, out_valid, out_ready;
    logic [31:0] in_a, in_b, out_x;
    logic [2:0]  out_flags;
    logic        h_valid, h_ready, h_sub, h_rnd, h_out_valid, h_out_ready;
    logic [15:0] h_a, h_b, h_x;
    logic [2:0]  h_flags;

    fp_add_pipe u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_rnd(in_rnd),
        .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_flags(out_flags)
    );

    fp_add_pipe #(.EXP_W(5), .MAN_W(10)) u_half (
        .clk(clk), .rst(rst), .in_valid(h_valid), .in_ready(h_ready),
        .in_a(h_a), .in_b(h_b), .in_sub(h_sub), .in_rnd(h_rnd),
        .out_valid(h_out_valid), .out_ready(h_out_ready), .out_x(h_x), .out_flags(h_flags)
    );

    typedef struct {
        string       nm;
        logic [31:0] x;
        logic [2:0]  f;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t sq[$];
    exp_t hq[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    // Single-precision monitor
    always @(negedge clk) begin
        exp_t e;
        if (out_valid) begin
            if (sq.size() == 0) begin
                check("spurious_out", {31'b0, out_valid}, 32'd0);
            end else if (out_ready) begin
                e = sq.pop_front();
                check({e.nm, "_x"}, out_x, e.x);
                check({e.nm, "_flags"}, 32'(out_flags), 32'(e.f));
                if (e.lat) check({e.nm, "_latency"}, 32'(cyc - e.acc), 32'd3);
            end else begin
                check({sq[0].nm, "_hold_x"}, out_x, sq[0].x);
                check({sq[0].nm, "_hold_flags"}, 32'(out_flags), 32'(sq[0].f));
                check("in_ready_stall", {31'b0, in_ready}, 32'd0);
            end
        end
    end

    // Half-precision monitor
    always @(negedge clk) begin
        exp_t e;
        if (h_out_valid) begin
            if (hq.size() == 0) begin
                check("h_spurious_out", {31'b0, h_out_valid}, 32'd0);
            end else begin
                e = hq.pop_front();
                check({e.nm, "_x"}, 32'(h_x), e.x);
                check({e.nm, "_flags"}, 32'(h_flags), 32'(e.f));
            end
        end
    end

    task automatic send(input string nm, input bit half, input logic [31:0] a,
                        input logic [31:0] b, input bit sub, input bit rnd,
                        input logic [31:0] x, input logic [2:0] f, input bit lat);
        exp_t e;
        int   n = 0;
        @(posedge clk);
        #1;
        if (half) begin
            h_valid = 1'b1; h_a = a[15:0]; h_b = b[15:0]; h_sub = sub; h_rnd = rnd;
        end else begin
            in_valid = 1'b1; in_a = a; in_b = b; in_sub = sub; in_rnd = rnd;
        end
        @(negedge clk);
        while (!(half ? h_ready : in_ready)) begin
            n++;
            if (n > 50) begin
                bad++;
                $display("FAIL %s_accept_timeout: in_ready stuck low", nm);
                $fatal(1, "accept timeout");
            end
            @(negedge clk);
        end
        e.nm = nm; e.x = x; e.f = f; e.acc = cyc; e.lat = lat;
        if (half) hq.push_back(e);
        else      sq.push_back(e);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        h_valid  = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sq.size() != 0 || hq.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_left", 32'(sq.size() + hq.size()), 32'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; in_rnd = 1'b0;
        out_ready = 1'b1; h_valid = 1'b0; h_a = '0; h_b = '0; h_sub = 1'b0; h_rnd = 1'b0;
        h_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_x", out_x, 32'd0);
        check("rst_out_flags", 32'(out_flags), 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);

        send("add_1_2", 0, 32'h3F800000, 32'h40000000, 0, 0, 32'h40400000, 3'b000, 1);
        idle();
        drain();

        send("sub_cancel", 0, 32'h3F800000, 32'h3F800000, 1, 0, 32'h00000000, 3'b000, 0);
        send("inf_m_inf", 0, 32'h7F800000, 32'hFF800000, 0, 0, 32'h7FC00000, 3'b100, 0);
        send("rne_tie_even", 0, 32'h3F800000, 32'h33800000, 0, 0, 32'h3F800000, 3'b001, 0);
        send("ovf_rne", 0, 32'h7F7FFFFF, 32'h7F7FFFFF, 0, 0, 32'h7F800000, 3'b011, 0);
        send("ovf_rtz", 0, 32'h7F7FFFFF, 32'h7F7FFFFF, 0, 1, 32'h7F7FFFFF, 3'b011, 0);
        send("rne_tie_odd", 0, 32'h3F800001, 32'h33800000, 0, 0, 32'h3F800002, 3'b001, 0);
        send("rtz_tie_odd", 0, 32'h3F800001, 32'h33800000, 0, 1, 32'h3F800001, 3'b001, 0);
        send("round_carry", 0, 32'h3FFFFFFF, 32'h33800000, 0, 0, 32'h40000000, 3'b001, 0);
        send("sub_2_1", 0, 32'h40000000, 32'h3F800000, 1, 0, 32'h3F800000, 3'b000, 0);
        send("neg_mix", 0, 32'hBFC00000, 32'h3F000000, 0, 0, 32'hBF800000, 3'b000, 0);
        send("opp_zero", 0, 32'h3F800000, 32'hBF800000, 0, 0, 32'h00000000, 3'b000, 0);
        send("qnan", 0, 32'h7FC00001, 32'h3F800000, 0, 0, 32'h7FC00000, 3'b000, 0);
        send("snan", 0, 32'h7F800001, 32'h00000000, 0, 0, 32'h7FC00000, 3'b100, 0);
        send("inf_fin", 0, 32'hFF800000, 32'h3F800000, 0, 0, 32'hFF800000, 3'b000, 0);
        send("subn_flush", 0, 32'h00400000, 32'h3F800000, 0, 0, 32'h3F800000, 3'b000, 0);
        send("sticky_far", 0, 32'h3F800000, 32'h00800000, 0, 0, 32'h3F800000, 3'b001, 0);
        send("underflow", 0, 32'h00800001, 32'h00800000, 1, 0, 32'h00000000, 3'b001, 0);
        idle();
        drain();

        // Backpressure: six back-to-back inputs, consumer stalls five cycles
        @(posedge clk);
        #1 out_ready = 1'b0;
        fork
            begin
                send("bp0", 0, 32'h3F800000, 32'h3F800000, 0, 0, 32'h40000000, 3'b000, 0);
                send("bp1", 0, 32'h3F800000, 32'h40000000, 0, 0, 32'h40400000, 3'b000, 0);
                send("bp2", 0, 32'h40000000, 32'h40000000, 0, 0, 32'h40800000, 3'b000, 0);
                send("bp3", 0, 32'h40400000, 32'h3F800000, 1, 0, 32'h40000000, 3'b000, 0);
                send("bp4", 0, 32'h3F800000, 32'h00000000, 0, 0, 32'h3F800000, 3'b000, 0);
                send("bp5", 0, 32'h40800000, 32'h40800000, 1, 0, 32'h00000000, 3'b000, 0);
                idle();
            end
            begin
                int n = 0;
                @(negedge clk);
                while (!out_valid && n < 20) begin
                    n++;
                    @(negedge clk);
                end
                check("bp_out_valid_seen", {31'b0, out_valid}, 32'd1);
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Reset mid-flight discards everything in the pipe
        @(posedge clk);
        #1 out_ready = 1'b0;
        send("rf0", 0, 32'h3F800000, 32'h40000000, 0, 0, 32'h40400000, 3'b000, 0);
        send("rf1", 0, 32'h40000000, 32'h40000000, 0, 0, 32'h40800000, 3'b000, 0);
        send("rf2", 0, 32'h3F800000, 32'h3F800000, 0, 0, 32'h40000000, 3'b000, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sq.delete();
        @(negedge clk);
        check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("mid_rst_out_x", out_x, 32'd0);
        check("mid_rst_out_flags", 32'(out_flags), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("mid_rst_quiet", {31'b0, out_valid}, 32'd0);
        end
        send("post_rst", 0, 32'h40000000, 32'h3F800000, 0, 0, 32'h40400000, 3'b000, 1);
        idle();
        drain();

        send("h_1p2", 1, 32'h3C00, 32'h4000, 0, 0, 32'h4200, 3'b000, 0);
        send("h_1p1", 1, 32'h3C00, 32'h3C00, 0, 0, 32'h4000, 3'b000, 0);
        send("h_ovf", 1, 32'h7BFF, 32'h7BFF, 0, 0, 32'h7C00, 3'b011, 0);
        send("h_ovf_rtz", 1, 32'h7BFF, 32'h7BFF, 0, 1, 32'h7BFF, 3'b011, 0);
        send("h_inf_m_inf", 1, 32'h7C00, 32'hFC00, 0, 0, 32'h7E00, 3'b100, 0);
        idle();
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
